// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead TX FIFO and sends each one as a
// UART frame (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-low reset
//   dvsr         baud divisor, one oversample tick every dvsr+1 clocks
//   fifo_empty   FIFO empty flag
//   fifo_r_data  FIFO head word, valid while fifo_empty is low
//   fifo_rd      one-cycle pop strobe, only ever raised in IDLE
//   tx           registered serial output, idle high
//   tx_busy      high from the start bit to the end of the stop bit
//   tx_done_tick one-cycle pulse on the last tick of the stop bit
//
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data.
module fifo_uart_tx #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int DVSR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DVSR_WIDTH-1:0] dvsr,
   input  logic                  fifo_empty,
   input  logic [DBIT-1:0]       fifo_r_data,
   output logic                  fifo_rd,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done_tick
);

   // s has to reach SB_TICK-1 in the stop bit, and 15 in every other bit
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
   localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;
`endif

   // ------------------------------------------------------------------
   // Baud tick generator
   // ------------------------------------------------------------------
   logic [DVSR_WIDTH-1:0] r_cnt;
   logic                  w_tick;

   // A counter already past a newly lowered dvsr simply runs on to the
   // all-ones value and wraps through zero before ticking again.
   assign w_tick = (r_cnt == dvsr);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DVSR_WIDTH'(1);
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t          r_state;
   state_t          w_state_nx;
   logic [SW-1:0]   r_s;
   logic [SW-1:0]   w_s_nx;
   logic [NW-1:0]   r_n;
   logic [NW-1:0]   w_n_nx;
   logic [DBIT-1:0] r_shift;
   logic [DBIT-1:0] w_shift_nx;
   logic            r_tx;
   logic            w_tx_nx;
   logic            w_load;

`ifdef UART_TX_PARITY_EN
   logic            r_par;

   // Parity is taken from the byte as popped, before any shifting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_par <= 1'b0;
      end else if (w_load) begin
         r_par <= ^fifo_r_data;
      end
   end
`endif

   // State register, plus the datapath registers that move with it
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_s     <= w_s_nx;
         r_n     <= w_n_nx;
         r_shift <= w_shift_nx;
         r_tx    <= w_tx_nx;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nx = r_state;
      w_s_nx     = r_s;
      w_n_nx     = r_n;
      w_shift_nx = r_shift;
      w_load     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // leaving IDLE does not wait for a tick
            if (!fifo_empty) begin
               w_load     = 1'b1;
               w_shift_nx = fifo_r_data;
               w_s_nx     = '0;
               w_state_nx = ST_START;
            end
         end
         ST_START: begin
            if (w_tick) begin
               if (r_s == S_BIT_LAST) begin
                  w_s_nx     = '0;
                  w_n_nx     = '0;
                  w_state_nx = ST_DATA;
               end else begin
                  w_s_nx = r_s + SW'(1);
               end
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_s == S_BIT_LAST) begin
                  w_s_nx     = '0;
                  w_shift_nx = r_shift >> 1;
                  if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                     w_state_nx = ST_PARITY;
`else
                     w_state_nx = ST_STOP;
`endif
                  end else begin
                     w_n_nx = r_n + NW'(1);
                  end
               end else begin
                  w_s_nx = r_s + SW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_tick) begin
               if (r_s == S_BIT_LAST) begin
                  w_s_nx     = '0;
                  w_state_nx = ST_STOP;
               end else begin
                  w_s_nx = r_s + SW'(1);
               end
            end
         end
`endif
         ST_STOP: begin
            if (w_tick) begin
               if (r_s == S_STOP_LAST) begin
                  w_s_nx     = '0;
                  w_state_nx = ST_IDLE;
               end else begin
                  w_s_nx = r_s + SW'(1);
               end
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      // pop and done are masked during reset so a held reset with a
      // non-empty FIFO never consumes a byte
      fifo_rd      = reset && (r_state == ST_IDLE) && !fifo_empty;
      tx_done_tick = reset && (r_state == ST_STOP) && w_tick &&
                     (r_s == S_STOP_LAST);
      tx_busy      = (r_state != ST_IDLE);
      tx           = r_tx;
      // tx is registered from the next state so the line changes on the
      // same edge as the state transition
      unique case (w_state_nx)
         ST_START: w_tx_nx = 1'b0;
         ST_DATA:  w_tx_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_tx_nx = r_par;
`endif
         default:  w_tx_nx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a small FIFO model.
// Captures each frame cycle by cycle and checks it against hand-built values.
module tb_fifo_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   // clocks from the pop cycle to the done pulse at dvsr=0
   localparam int FLEN = 160 + 16 * P;

   logic        clk;
   logic        reset;
   logic [10:0] dvsr;
   logic        fifo_empty;
   logic [7:0]  fifo_r_data;
   logic        fifo_rd;
   logic        tx;
   logic        tx_busy;
   logic        tx_done_tick;

   logic [7:0]  mem [0:15];
   logic [4:0]  wr_ptr = '0;
   logic [4:0]  rd_ptr = '0;

   logic        cap_tx   [0:799];
   logic        cap_rd   [0:799];
   logic        cap_busy [0:799];
   logic        cap_done [0:799];

   int n_vec = 0;
   int n_bad = 0;

   fifo_uart_tx dut (
      .clk          (clk),
      .reset        (reset),
      .dvsr         (dvsr),
      .fifo_empty   (fifo_empty),
      .fifo_r_data  (fifo_r_data),
      .fifo_rd      (fifo_rd),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_r_data = mem[rd_ptr[3:0]];

   always @(posedge clk) begin
      if (fifo_rd) begin
         rd_ptr <= rd_ptr + 5'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[3:0]] = b;
      wr_ptr = wr_ptr + 5'd1;
   endtask

   task automatic wait_pop(input string tag, input int lim);
      int i;
      i = 0;
      while (!fifo_rd && i < lim) begin
         @(negedge clk);
         i++;
      end
      chk(tag, 32'(fifo_rd), 32'd1);
   endtask

   // index 0 is the pop cycle; index k is k clocks later
   task automatic capture(input int n);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         cap_tx[k]   = tx;
         cap_rd[k]   = fifo_rd;
         cap_busy[k] = tx_busy;
         cap_done[k] = tx_done_tick;
      end
   endtask

   // dvsr=0 frame popped at cycle base: bit j occupies cycles
   // base+1+16j .. base+16+16j, sampled mid-bit at base+8+16j
   task automatic check_frame(input string tag, input logic [7:0] b,
                              input int base);
      int nd;
      chk({tag, ".start"}, 32'(cap_tx[base+8]), 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s.d%0d", tag, i),
             32'(cap_tx[base+24+16*i]), 32'(b[i]));
      end
`ifdef UART_TX_PARITY_EN
      chk({tag, ".par"}, 32'(cap_tx[base+152]), 32'(^b));
`endif
      chk({tag, ".stop"}, 32'(cap_tx[base+8+16*(9+P)]), 32'd1);
      chk({tag, ".busy"}, 32'(cap_busy[base+FLEN]), 32'd1);
      chk({tag, ".done"}, 32'(cap_done[base+FLEN]), 32'd1);
      nd = 0;
      for (int k = base + 1; k <= base + FLEN; k++) begin
         nd += int'(cap_done[k]);
      end
      chk({tag, ".ndone"}, 32'(nd), 32'd1);
      chk({tag, ".idle"}, 32'(cap_busy[base+FLEN+1]), 32'd0);
   endtask

   function automatic int find_tx(input int from, input logic v,
                                  input int lim);
      for (int k = from; k <= lim; k++) begin
         if (cap_tx[k] === v) return k;
      end
      return -1;
   endfunction

   initial begin
      int npop;
      int f, r, l, s, d, nd;

      reset = 1'b0;
      dvsr  = '0;

      // 1: reset held with a non-empty FIFO
      push(8'hA5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst%0d.tx", i), 32'(tx), 32'd1);
         chk($sformatf("rst%0d.rd", i), 32'(fifo_rd), 32'd0);
         chk($sformatf("rst%0d.busy", i), 32'(tx_busy), 32'd0);
         chk($sformatf("rst%0d.done", i), 32'(tx_done_tick), 32'd0);
      end

      // 2: single byte 0xA5
      reset = 1'b1;
      #1;
      wait_pop("a5.pop", 4);
      capture(FLEN + 4);
      check_frame("a5", 8'hA5, 0);
      npop = 0;
      for (int k = 1; k <= FLEN + 4; k++) npop += int'(cap_rd[k]);
      chk("a5.npop", 32'(npop), 32'd0);

      // 3: back-to-back 0x00 then 0xFF
      push(8'h00);
      push(8'hFF);
      #1;
      wait_pop("b2b.pop", 4);
      capture(2 * FLEN + 10);
      check_frame("f00", 8'h00, 0);
      check_frame("fFF", 8'hFF, FLEN + 1);
      chk("b2b.pop2", 32'(cap_rd[FLEN+1]), 32'd1);
      chk("b2b.gap", 32'(cap_tx[FLEN+1]), 32'd1);
      chk("b2b.st2", 32'(cap_tx[FLEN+2]), 32'd0);
      npop = 0;
      for (int k = 1; k <= 2 * FLEN + 10; k++) npop += int'(cap_rd[k]);
      chk("b2b.npop", 32'(npop), 32'd1);

      // 5: reset in the middle of bit 4 of 0x55
      push(8'h55);
      #1;
      wait_pop("r55.pop", 4);
      capture(88);
      chk("r55.b3", 32'(cap_tx[72]), 32'd0);
      chk("r55.b4", 32'(cap_tx[88]), 32'd1);
      reset = 1'b0;
      push(8'h96);
      @(negedge clk);
      chk("r55.tx", 32'(tx), 32'd1);
      chk("r55.busy", 32'(tx_busy), 32'd0);
      chk("r55.rd", 32'(fifo_rd), 32'd0);
      @(negedge clk);
      chk("r55.hold", 32'(fifo_rd), 32'd0);
      reset = 1'b1;
      #1;
      wait_pop("f96.pop", 4);
      capture(FLEN + 4);
      check_frame("f96", 8'h96, 0);

`ifdef UART_TX_PARITY_EN
      // 6: parity 0x07 -> 1, 0x03 -> 0
      push(8'h07);
      push(8'h03);
      #1;
      wait_pop("par.pop", 4);
      capture(2 * FLEN + 10);
      check_frame("f07", 8'h07, 0);
      check_frame("f03", 8'h03, FLEN + 1);
`endif

      // 4: dvsr=3, byte 0x3C -> LSB first 0,0,1,1,1,1,0,0
      dvsr = 11'd3;
      push(8'h3C);
      #1;
      wait_pop("d3.pop", 8);
      capture(4 * FLEN + 16);
      f = find_tx(1, 1'b0, 4 * FLEN + 16);
      r = find_tx(f + 1, 1'b1, 4 * FLEN + 16);
      l = find_tx(r + 1, 1'b0, 4 * FLEN + 16);
      s = find_tx(l + 1, 1'b1, 4 * FLEN + 16);
      d = -1;
      nd = 0;
      for (int k = 1; k <= 4 * FLEN + 16; k++) begin
         if (cap_done[k]) begin
            nd++;
            if (d < 0) d = k;
         end
      end
      chk("d3.fall", 32'(f), 32'd1);
      chk("d3.low1", 32'(r - f >= 189 && r - f <= 192), 32'd1);
      chk("d3.high", 32'(l - r), 32'd256);
      chk("d3.low2", 32'(s - l), 32'(128 + 64 * P));
      chk("d3.stop", 32'(d - s + 1), 32'd64);
      chk("d3.frame", 32'(d >= 4 * FLEN - 4 && d <= 4 * FLEN), 32'd1);
      chk("d3.ndone", 32'(nd), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
